// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD match reporter.
package sad_pkg;

  localparam int SAD_COLS = 600;
  localparam int SAD_ROWS = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    EMPTY = 2'd2
  } sad_state_e;

endpackage

// File: rtl/sad_prio_enc.sv
// Lowest-set-bit priority encoder over a COLS-wide flag vector.
module sad_prio_enc
  import sad_pkg::*;
#(
  parameter int COLS = SAD_COLS
) (
  input  logic [COLS-1:0] vec,
  output logic [X_W-1:0]  idx,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (vec[i]) idx = X_W'(i);
    end
  end

endmodule

// File: rtl/sad_match_reporter.sv
// Serialises one row of SAD match flags into (x, y) coordinates, one per
// accepted handshake, and tracks the row position within a frame.
// Optional feature: define SAD_MATCH_COUNT_EN to add a saturating
// match_count output (accepted matches since reset/frame_start).
module sad_match_reporter
  import sad_pkg::*;
#(
  parameter int COLS = SAD_COLS,
  parameter int ROWS = SAD_ROWS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            flag_valid,
  input  logic [COLS-1:0] flag_vec,
  output logic            flag_ready,
  output logic            m_valid,
  output logic [X_W-1:0]  m_x,
  output logic [Y_W-1:0]  m_y,
  output logic            m_last,
  input  logic            m_ready,
  output logic            frame_done
`ifdef SAD_MATCH_COUNT_EN
  ,
  output logic [15:0]     match_count
`endif
);

  sad_state_e      state_q, state_d;
  logic [COLS-1:0] pend_q;
  logic [COLS-1:0] pend_clr;
  logic [Y_W-1:0]  row_q;
  logic [Y_W-1:0]  row_cnt_q;
  logic [X_W-1:0]  enc_idx;
  logic            enc_any;
  logic            row_hs;
  logic            m_hs;
  logic            row_adv;
  logic            cnt_wrap;
  logic            in_scan;

  sad_prio_enc #(.COLS(COLS)) u_prio_enc (
    .vec (pend_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Pending vector with its lowest set bit removed.
  assign pend_clr = pend_q & (pend_q - {{(COLS-1){1'b0}}, 1'b1});
  assign in_scan  = (state_q == SCAN);
  assign m_x      = in_scan ? enc_idx : '0;
  assign m_y      = in_scan ? row_q : '0;
  assign m_last   = in_scan && enc_any && (pend_clr == '0);
  assign row_hs   = flag_valid && flag_ready;
  assign m_hs     = m_valid && m_ready;
  assign cnt_wrap = (row_cnt_q == Y_W'(ROWS - 1));

  // A frame only completes if frame_start does not override the wrap.
  assign frame_done = row_adv && cnt_wrap && !frame_start;

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    flag_ready = 1'b0;
    m_valid    = 1'b0;
    row_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        flag_ready = 1'b1;
        if (flag_valid) state_d = (|flag_vec) ? SCAN : EMPTY;
      end
      SCAN: begin
        m_valid = 1'b1;
        if (m_ready && m_last) begin
          state_d = IDLE;
          row_adv = 1'b1;
        end
      end
      EMPTY: begin
        row_adv = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latch a new row, then retire one flag per accepted match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      row_q  <= '0;
    end else if (row_hs) begin
      pend_q <= flag_vec;
      row_q  <= row_cnt_q;
    end else if (m_hs) begin
      pend_q <= pend_clr;
    end
  end

  // Row counter; frame_start has priority over a coincident advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             row_cnt_q <= '0;
    else if (frame_start) row_cnt_q <= '0;
    else if (row_adv)     row_cnt_q <= cnt_wrap ? '0 : row_cnt_q + 1'b1;
  end

`ifdef SAD_MATCH_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating count of accepted matches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             match_count <= '0;
    else if (frame_start) match_count <= '0;
    else if (m_hs)        match_count <= sat_inc16(match_count);
  end
`endif

endmodule

// File: tb/tb_sad_match_reporter.sv
// Scoreboard bench for sad_match_reporter (COLS=600, ROWS=4).
module tb_sad_match_reporter;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start;
  logic         flag_valid;
  logic [599:0] flag_vec;
  logic         flag_ready;
  logic         m_valid;
  logic [9:0]   m_x;
  logic [8:0]   m_y;
  logic         m_last;
  logic         m_ready;
  logic         frame_done;
`ifdef SAD_MATCH_COUNT_EN
  logic [15:0]  match_count;
`endif

  typedef struct {
    int x;
    int y;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_count = 0;

  sad_match_reporter #(.COLS(600), .ROWS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .flag_valid  (flag_valid),
    .flag_vec    (flag_vec),
    .flag_ready  (flag_ready),
    .m_valid     (m_valid),
    .m_x         (m_x),
    .m_y         (m_y),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .frame_done  (frame_done)
`ifdef SAD_MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [599:0] bits3(input int a, input int b, input int c);
    logic [599:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic push(input int x, input int y, input int last);
    exp_t e;
    e.x = x; e.y = y; e.last = last;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the row handshake.
  task automatic send_row(input logic [599:0] v);
    int n = 0;
    while (!flag_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("flag_ready_wait", int'(flag_ready), 1);
    flag_vec   = v;
    flag_valid = 1'b1;
    @(posedge clk); #1;
    flag_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!flag_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", int'(flag_ready), 1);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Monitor: pop and compare on every accepted match.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_match: got x=%0d y=%0d, required no match", m_x, m_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("m_x", int'(m_x), e.x);
        chk("m_y", int'(m_y), e.y);
        chk("m_last", int'(m_last), e.last);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && frame_done) fd_count++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    rst         = 1'b0;
    frame_start = 1'b0;
    flag_valid  = 1'b0;
    flag_vec    = '0;
    m_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_x", int'(m_x), 0);
    chk("rst_m_y", int'(m_y), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_flag_ready", int'(flag_ready), 1);

    // Row 0 with flags {3,17,599}
    push(3, 0, 0); push(17, 0, 0); push(599, 0, 1);
    send_row(bits3(3, 17, 599));
    chk("latency_m_valid", int'(m_valid), 1);
    chk("latency_m_x", int'(m_x), 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scan_flag_ready", int'(flag_ready), 0);
    @(posedge clk); #1;
    chk("after_row_flag_ready", int'(flag_ready), 1);

    // All-zero row 0, then next row reports y=1 under backpressure
    pulse_frame_start();
    send_row('0);
    chk("empty_m_valid", int'(m_valid), 0);
    chk("empty_flag_ready", int'(flag_ready), 0);
    @(posedge clk); #1;
    chk("empty_done_flag_ready", int'(flag_ready), 1);

    m_ready = 1'b0;
    push(5, 1, 0); push(6, 1, 1);
    send_row(bits3(5, 6, -1));
    for (int i = 0; i < 4; i++) begin
      chk("hold_m_valid", int'(m_valid), 1);
      chk("hold_m_x", int'(m_x), 5);
      chk("hold_m_y", int'(m_y), 1);
      chk("hold_flag_ready", int'(flag_ready), 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_after_flag_ready", int'(flag_ready), 1);

    // Frame wrap with ROWS=4
    pulse_frame_start();
    fd0 = fd_count;
    for (int r = 0; r < 4; r++) begin
      push(10 + r, r, 1);
      send_row(bits3(10 + r, -1, -1));
    end
    @(posedge clk); #1;
    chk("frame_done_pulses", fd_count - fd0, 1);
    push(0, 0, 1);
    send_row(bits3(0, -1, -1));
    @(posedge clk); #1;

    // frame_start coinciding with the wrap advance suppresses frame_done
    push(11, 1, 1); send_row(bits3(11, -1, -1));
    push(12, 2, 1); send_row(bits3(12, -1, -1));
    push(20, 3, 1); send_row(bits3(20, -1, -1));
    fd0 = fd_count;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("coincide_no_frame_done", fd_count - fd0, 0);
    push(30, 0, 1);
    send_row(bits3(30, -1, -1));
    @(posedge clk); #1;

    // Reset mid-scan after one of three matches
    push(1, 1, 0);
    send_row(bits3(1, 2, 3));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_m_x", int'(m_x), 0);
    chk("midrst_m_y", int'(m_y), 0);
    chk("midrst_m_last", int'(m_last), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_flag_ready", int'(flag_ready), 1);
    push(7, 0, 1);
    send_row(bits3(7, -1, -1));
    @(posedge clk); #1;

`ifdef SAD_MATCH_COUNT_EN
    pulse_frame_start();
    for (int r = 0; r < 117; r++) begin
      for (int b = 0; b < 600; b++) push(b, r % 4, (b == 599) ? 1 : 0);
      send_row('1);
      if (r == 0) begin
        wait_idle();
        chk("match_count_600", int'(match_count), 600);
      end
    end
    wait_idle();
    chk("match_count_sat", int'(match_count), 65535);
    pulse_frame_start();
    chk("match_count_clear", int'(match_count), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_match_reporter.md
SAD_MATCH_REPORTER -- requirements
Module: sad_match_reporter

Interface
REQ-001 SHALL have parameter COLS, default 600, meaning the width of the SAD flag vector (one bit per candidate column).
REQ-002 SHALL have parameter ROWS, default 480, meaning the number of flag rows per frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port frame_start, input, 1, a one-cycle pulse that restarts the row counter at 0.
REQ-006 SHALL have port flag_valid, input, 1, indicating that flag_vec holds one row of sad_flag results.
REQ-007 SHALL have port flag_vec, input, COLS, the per-column match flags from the vertical processor (bit x=1 means SAD matched at column x).
REQ-008 SHALL have port flag_ready, output, 1, high when a new row is accepted.
REQ-009 SHALL have port m_valid, input/output direction output, 1, indicating a match coordinate is presented.
REQ-010 SHALL have port m_x, output, 10, the match column.
REQ-011 SHALL have port m_y, output, 9, the match row.
REQ-012 SHALL have port m_last, output, 1, marking the final match of the current row.
REQ-013 SHALL have port m_ready, input, 1, the downstream acceptance signal.
REQ-014 SHALL have port frame_done, output, 1, a one-cycle pulse when row ROWS-1 has been fully reported.

Function
REQ-015 SHALL implement the FSM states IDLE, SCAN and EMPTY.
REQ-016 In IDLE, flag_ready SHALL be 1; a handshake (flag_valid&flag_ready) SHALL latch flag_vec into the pending register and latch the row counter into the row register.
REQ-017 IDLE SHALL move to SCAN if the latched vector is nonzero, else to EMPTY.
REQ-018 EMPTY SHALL last one cycle, emit no match, advance the row and return to IDLE.
REQ-019 In SCAN, m_valid SHALL be 1; m_x SHALL be the lowest set bit index of the pending register; m_y SHALL be the latched row.
REQ-020 On a m_valid&m_ready handshake, that bit SHALL be cleared; when the cleared bit was the last set bit (m_last=1), the row SHALL advance and the FSM SHALL return to IDLE.
REQ-021 While m_ready=0, m_x, m_y and m_last SHALL be held stable.
REQ-022 Latency from a row handshake to the first m_valid SHALL be 1 cycle; matches SHALL be emitted at one per cycle under constant m_ready.
REQ-023 flag_ready SHALL be 0 in SCAN and EMPTY; no row is dropped.
REQ-024 The row advance SHALL increment the row counter; at ROWS-1 it SHALL wrap to 0 and pulse frame_done in the same cycle.
REQ-025 frame_start SHALL zero the row counter; if it coincides with a row advance, frame_start SHALL win and frame_done SHALL NOT pulse.
REQ-026 frame_start during SCAN SHALL NOT abort the row in progress; that row keeps its latched m_y.

Reset
REQ-027 When rst=0, the FSM SHALL asynchronously go to IDLE, with pending and row registers cleared, m_valid=0, m_x=0, m_y=0, m_last=0 and frame_done=0; flag_ready SHALL be 1 after release.
REQ-028 Reset during SCAN SHALL discard the remaining matches of that row.

Configuration
REQ-029 With SAD_MATCH_COUNT_EN defined, the block SHALL add an output match_count[15:0], counting m_valid&m_ready handshakes, saturating at 65535, zeroed by rst or frame_start.
REQ-030 Without SAD_MATCH_COUNT_EN, the match_count port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package sad_pkg SHALL hold the constants SAD_COLS=600, SAD_ROWS=480, X_W=10 and Y_W=9, and the FSM state typedef.
REQ-032 Lowest-set-bit search SHALL be a sub-module sad_prio_enc (input COLS vector; outputs index and any).

Verification
REQ-033 Row 0 with flags {3,17,599} and m_ready=1 -> (3,0,last0), (17,0,last0), (599,0,last1) on consecutive cycles, then flag_ready=1.
REQ-034 An all-zero row -> no m_valid, EMPTY for one cycle, and the next row reports m_y=1.
REQ-035 Two matches {5,6} with m_ready=0 for 4 cycles -> m_x=5 held and flag_ready=0 throughout, then 5 then 6 once m_ready=1.
REQ-036 ROWS=4, with 4 rows streamed -> frame_done pulses once on the 4th row advance and the next row reports m_y=0.
REQ-037 rst low mid-SCAN after 1 of 3 matches -> m_valid=0 immediately; after release the next row reports m_y=0.
REQ-038 With SAD_MATCH_COUNT_EN, 70000 accepted matches -> match_count=65535; then frame_start -> 0.
